// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debounce stage: FSM encoding and
// the board timing constants the default debounce length is derived from.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } dbnc_state_e;

  localparam int unsigned CLK_FREQ_HZ = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; the reset value lets each
// pin-input stage load its idle level so reset never looks like activity.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronised pin feeds a four-state filter FSM that
// emits one-cycle press/release pulses and a registered debounced level.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic key_sync;
  logic key_s;

  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             rel_q, rel_d;
  logic             level_q, level_d;

  sync_2ff #(
    .RST_VAL(KEY_ACTIVE_LOW)
  ) u_sync (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .d      (key_in),
    .q      (key_sync)
  );

  assign key_s = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      rel_q   <= rel_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (key_s) state_d = PRESS_FILT;
      end
      PRESS_FILT: begin
        // A mismatch wins over the terminal count, so a last-cycle bounce aborts.
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DOWN;
          cnt_d   = '0;
          flag_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        cnt_d = '0;
        if (!key_s) state_d = REL_FILT;
      end
      REL_FILT: begin
        if (key_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == DOWN) || (state_d == REL_FILT);
  end

  assign key_flag    = flag_q;
  assign key_release = rel_q;
  assign key_state   = level_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with an 8-cycle filter and active-low pin.
module tb_key_debounce;

  logic sys_clk;
  logic sys_rst;
  logic key_in;
  logic key_flag;
  logic key_release;
  logic key_state;

  int n_checks;
  int n_pass;

  // Per-window observations; *_at is the 1-based sample index, 0 if never seen.
  int mon_flags, mon_flag_at, mon_rels, mon_rel_at, mon_both, mon_up_at, mon_dn_at;

  key_debounce #(
    .DEBOUNCE_CYCLES(8),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_flag   (key_flag),
    .key_release(key_release),
    .key_state  (key_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run(input int n);
    logic prev_state;
    prev_state  = key_state;
    mon_flags   = 0; mon_flag_at = 0;
    mon_rels    = 0; mon_rel_at  = 0;
    mon_both    = 0; mon_up_at   = 0; mon_dn_at = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (key_flag) begin
        mon_flags++;
        if (mon_flag_at == 0) mon_flag_at = i;
      end
      if (key_release) begin
        mon_rels++;
        if (mon_rel_at == 0) mon_rel_at = i;
      end
      if (key_flag && key_release) mon_both++;
      if (key_state && !prev_state && mon_up_at == 0) mon_up_at = i;
      if (!key_state && prev_state && mon_dn_at == 0) mon_dn_at = i;
      prev_state = key_state;
    end
  endtask

  initial begin
    int bounce_flags;
    int bounce_rels;
    n_checks = 0;
    n_pass   = 0;
    sys_rst  = 1'b1;
    key_in   = 1'b1;

    // 1. reset with button released
    repeat (3) step();
    chk("rst_flag", key_flag, 0);
    chk("rst_release", key_release, 0);
    chk("rst_state", key_state, 0);
    sys_rst = 1'b0;
    run(15);
    chk("post_rst_flags", mon_flags, 0);
    chk("post_rst_rels", mon_rels, 0);
    chk("post_rst_state", key_state, 0);

    // 2. clean press: flag sampled after edge E0+10 (11th sample)
    key_in = 1'b0;
    run(20);
    chk("press_flags", mon_flags, 1);
    chk("press_flag_at", mon_flag_at, 11);
    chk("press_state_up_at", mon_up_at, 11);
    chk("press_rels", mon_rels, 0);
    chk("press_state", key_state, 1);

    // 5. clean release from DOWN
    key_in = 1'b1;
    run(20);
    chk("rel_rels", mon_rels, 1);
    chk("rel_rel_at", mon_rel_at, 11);
    chk("rel_state_dn_at", mon_dn_at, 11);
    chk("rel_flags", mon_flags, 0);
    chk("rel_both", mon_both, 0);
    chk("rel_state", key_state, 0);

    // 3. bounce: 10 segments of 3 cycles starting low, then hold pressed
    bounce_flags = 0;
    bounce_rels  = 0;
    for (int s = 0; s < 10; s++) begin
      key_in = (s % 2 == 0) ? 1'b0 : 1'b1;
      run(3);
      bounce_flags += mon_flags;
      bounce_rels  += mon_rels;
    end
    chk("bounce_flags", bounce_flags, 0);
    chk("bounce_rels", bounce_rels, 0);
    key_in = 1'b0;
    run(20);
    chk("bounce_hold_flags", mon_flags, 1);
    chk("bounce_hold_flag_at", mon_flag_at, 11);
    chk("bounce_hold_state", key_state, 1);
    key_in = 1'b1;
    run(20);
    chk("bounce_release", mon_rels, 1);

    // 4. glitch exactly on the last filter cycle
    key_in = 1'b0;
    run(8);
    bounce_flags = mon_flags;
    key_in = 1'b1;
    run(12);
    chk("glitch_flags", bounce_flags + mon_flags, 0);
    chk("glitch_state_up", mon_up_at, 0);
    chk("glitch_state", key_state, 0);

    // 6. reset during REL_FILT with the pin pressed through deassertion
    key_in = 1'b0;
    run(20);
    chk("rst6_press_flags", mon_flags, 1);
    key_in = 1'b1;
    run(5);
    chk("rst6_relfilt_state", key_state, 1);
    chk("rst6_relfilt_rels", mon_rels, 0);
    sys_rst = 1'b1;
    key_in  = 1'b0;
    step();
    chk("rst6_state", key_state, 0);
    chk("rst6_release", key_release, 0);
    chk("rst6_flag", key_flag, 0);
    step();
    sys_rst = 1'b0;
    run(20);
    chk("rst6_repress_flags", mon_flags, 1);
    chk("rst6_repress_flag_at", mon_flag_at, 11);
    chk("rst6_repress_rels", mon_rels, 0);
    chk("rst6_repress_state", key_state, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
